alu_exec_unit: RTL

//  Sequential ALU execute stage; consumer of the 4-bit ALU_sel produced by the ALU control decoder.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_exec_unit_if.sv | 32 +++
 rtl/alu_shift_step.sv | 48 ++++
 rtl/alu_exec_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes, FSM state encoding and helpers
// Purpose: single source of truth for the 4-bit ALU_sel encoding used by the
//   ALU control decoder and the alu_exec_unit execute stage.
// Ports: none (package).
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_PASS = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// rtl/alu_exec_unit_if.sv - operand/result handshake bundle for the ALU execute stage
// Purpose: groups the request (in_*, alu_sel, op_a, op_b) and response
//   (out_*, result, flags) handshakes of alu_exec_unit.
// Ports:
//   master : issuing side (ID/EX operand mux + writeback consumer)
//   slave  : alu_exec_unit
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, alu_sel, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, alu_sel, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational SLL/SRL/SRA step or full barrel shift
// Purpose: FAST_SHIFT=0 shifts data_i by exactly one bit (iterative datapath);
//   FAST_SHIFT=1 shifts data_i by shamt_i in one go.
// Ports:
//   sel_i   in  4        operation code (only SLL/SRL/SRA shift, others pass through)
//   data_i  in  WIDTH    value to shift
//   shamt_i in  SHAMT_W  shift amount (barrel mode only)
//   data_o  out WIDTH    shifted value
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int FAST_SHIFT = 0
) (
  input  logic [3:0]         sel_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  output logic [WIDTH-1:0]   data_o
);

  if (FAST_SHIFT != 0) begin : g_barrel
    always_comb begin
      data_o = data_i;
      case (sel_i)
        ALU_SLL: data_o = data_i << shamt_i;
        ALU_SRL: data_o = data_i >> shamt_i;
        ALU_SRA: data_o = $signed(data_i) >>> shamt_i;
        default: data_o = data_i;
      endcase
    end
  end else begin : g_step
    // Iterative mode: the amount lives in the caller's down-counter.
    logic unused_shamt;
    assign unused_shamt = ^shamt_i;

    always_comb begin
      data_o = data_i;
      case (sel_i)
        ALU_SLL: data_o = {data_i[WIDTH-2:0], 1'b0};
        ALU_SRL: data_o = {1'b0, data_i[WIDTH-1:1]};
        ALU_SRA: data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
        default: data_o = data_i;
      endcase
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - sequential ALU execute stage with valid/ready handshakes
// Purpose: accepts one op in IDLE, produces a registered result and flags
//   that are held in DONE until the consumer takes them. Shifts walk one bit
//   per cycle through SHIFT unless FAST_SHIFT=1.
// Ports:
//   clk  in  1   rising-edge clock
//   rst  in  1   synchronous reset, active-high
//   bus  slave modport of alu_exec_unit_if (request + response handshakes)
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHAMT_W    = $clog2(WIDTH),
  parameter int FAST_SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  alu_exec_unit_if.slave  bus
);

  alu_state_e          state_q, state_d;
  logic [3:0]          sel_q, sel_d;
  logic [WIDTH-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0]  count_q, count_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic                zero_q, zero_d;
  logic                neg_q, neg_d;
  logic                carry_q, carry_d;
  logic                ovf_q, ovf_d;

  logic [SHAMT_W-1:0]  shamt_in;
  logic [3:0]          sh_sel;
  logic [WIDTH-1:0]    sh_data;
  logic [WIDTH-1:0]    sh_out;

  logic                is_sub;
  logic [WIDTH-1:0]    b_eff;
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH-1:0]    acc_res;
  logic                acc_carry;
  logic                acc_ovf;

  assign shamt_in = bus.op_b[SHAMT_W-1:0];

  // Barrel mode shifts the live operand at accept; iterative mode steps the
  // captured working value.
  assign sh_sel  = (FAST_SHIFT != 0) ? bus.alu_sel : sel_q;
  assign sh_data = (FAST_SHIFT != 0) ? bus.op_a    : work_q;

  alu_shift_step #(
    .WIDTH      (WIDTH),
    .SHAMT_W    (SHAMT_W),
    .FAST_SHIFT (FAST_SHIFT)
  ) u_shift (
    .sel_i   (sh_sel),
    .data_i  (sh_data),
    .shamt_i (shamt_in),
    .data_o  (sh_out)
  );

  // SUB is a + ~b + 1 so carry-out means "no borrow" (a >= b unsigned).
  assign is_sub  = (bus.alu_sel == ALU_SUB);
  assign b_eff   = is_sub ? ~bus.op_b : bus.op_b;
  assign sum_ext = {1'b0, bus.op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  // Result of every op that completes in the accept cycle.
  always_comb begin
    acc_res   = '0;
    acc_carry = 1'b0;
    acc_ovf   = 1'b0;
    case (bus.alu_sel)
      ALU_ADD, ALU_SUB: begin
        acc_res   = sum_ext[WIDTH-1:0];
        acc_carry = sum_ext[WIDTH];
        acc_ovf   = (bus.op_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      ALU_AND:  acc_res = bus.op_a & bus.op_b;
      ALU_OR:   acc_res = bus.op_a | bus.op_b;
      ALU_XOR:  acc_res = bus.op_a ^ bus.op_b;
      // Only reached here for barrel mode or shamt==0 (sh_out == op_a then).
      ALU_SLL, ALU_SRL, ALU_SRA:
        acc_res = (FAST_SHIFT != 0) ? sh_out : bus.op_a;
      ALU_SLT:  acc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      ALU_SLTU: acc_res = {{(WIDTH-1){1'b0}}, (bus.op_a < bus.op_b)};
      ALU_PASS: acc_res = bus.op_b;
      default:  acc_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    work_d   = work_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          sel_d = bus.alu_sel;
          if (is_shift(bus.alu_sel) && (FAST_SHIFT == 0) && (shamt_in != '0)) begin
            work_d  = bus.op_a;
            count_d = shamt_in;
            state_d = ST_SHIFT;
          end else begin
            result_d = acc_res;
            zero_d   = (acc_res == '0);
            neg_d    = acc_res[WIDTH-1];
            carry_d  = acc_carry;
            ovf_d    = acc_ovf;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (count_q == SHAMT_W'(1)) begin
          result_d = sh_out;
          zero_d   = (sh_out == '0);
          neg_d    = sh_out[WIDTH-1];
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = ST_DONE;
        end else begin
          work_d  = sh_out;
          count_d = count_q - SHAMT_W'(1);
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      work_q   <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      work_q   <= work_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = ovf_q;

endmodule
